dbg_seg_router: RTL and testbench

Parametrised debug-bus segment router for the MCS-4 debug interface. It accepts single debug read/write requests on a flat address and decodes the top address bits into a segment index. Each request goes to one of `2**SEG_IDX_W` segment ports over a valid/ready handshake, and the router waits for that segment's response. Unmapped segments and stalled segments return an error response. It sits between the host-side debug master and the CTL/ROM/RAM/IO segment handlers, and generalises the fixed four-segment, 14-bit debug map to any width, segment count and enable mask.

---
 rtl/dbg_seg_router_if.sv | 42 ++++
 rtl/dbg_seg_router.sv | 191 +++++++++++++++++++
 tb/tb_dbg_seg_router.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_seg_router_if.sv
// Debug bus bundle between the host-side debug master, the segment router and the segment handlers.
// The router takes the slave view; the host/segment environment takes the master view.
interface dbg_seg_router_if #(
   parameter int ADDR_W    = 14,
   parameter int SEG_IDX_W = 2,
   parameter int DATA_W    = 8
);
   localparam int N_SEG      = 2 ** SEG_IDX_W;
   localparam int SEG_ADDR_W = ADDR_W - SEG_IDX_W;

   logic                    req_valid;
   logic                    req_ready;
   logic [ADDR_W-1:0]       req_addr;
   logic                    req_we;
   logic [DATA_W-1:0]       req_wdata;

   logic                    rsp_valid;
   logic [DATA_W-1:0]       rsp_rdata;
   logic                    rsp_err;

   logic [N_SEG-1:0]        seg_req_valid;
   logic [SEG_ADDR_W-1:0]   seg_req_addr;
   logic                    seg_req_we;
   logic [DATA_W-1:0]       seg_req_wdata;
   logic [N_SEG-1:0]        seg_req_ready;
   logic [N_SEG-1:0]        seg_rsp_valid;
   logic [N_SEG*DATA_W-1:0] seg_rsp_rdata;

   modport slave (
      input  req_valid, req_addr, req_we, req_wdata,
      input  seg_req_ready, seg_rsp_valid, seg_rsp_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output seg_req_valid, seg_req_addr, seg_req_we, seg_req_wdata
   );

   modport master (
      output req_valid, req_addr, req_we, req_wdata,
      output seg_req_ready, seg_rsp_valid, seg_rsp_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  seg_req_valid, seg_req_addr, seg_req_we, seg_req_wdata
   );
endinterface

// File: rtl/dbg_seg_router.sv
// Debug-bus segment router: decodes the top address bits of a single host request into a
// segment index, hands it to that segment over valid/ready and returns its response or an error.
module dbg_seg_router #(
   parameter int                     ADDR_W    = 14,
   parameter int                     SEG_IDX_W = 2,
   parameter int                     DATA_W    = 8,
   parameter logic [2**SEG_IDX_W-1:0] SEG_EN   = '1,
   parameter int                     TIMEOUT   = 255
) (
   input  logic             clk,
   input  logic             rst,
   dbg_seg_router_if.slave  bus,
   output logic [7:0]       err_count,
   output logic             busy
);
   localparam int N_SEG      = 2 ** SEG_IDX_W;
   localparam int SEG_ADDR_W = ADDR_W - SEG_IDX_W;
   localparam int TMO_W      = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                state;
   state_t                state_next;

   logic [SEG_IDX_W-1:0]  idx;
   logic [SEG_IDX_W-1:0]  req_idx;
   logic [SEG_ADDR_W-1:0] seg_addr_q;
   logic                  seg_we_q;
   logic [DATA_W-1:0]     seg_wdata_q;
   logic [N_SEG-1:0]      seg_valid_q;
   logic [DATA_W-1:0]     rsp_rdata_q;
   logic                  rsp_err_q;
   logic [TMO_W-1:0]      tmo_cnt;
   logic [7:0]            err_cnt_q;

   logic                  mapped;
   logic                  sel_ready;
   logic                  sel_rsp;
   logic [DATA_W-1:0]     sel_rdata;
   logic                  tmo_hit;

   logic                  accept;
   logic                  capture;
   logic                  cap_err;
   logic [DATA_W-1:0]     cap_data;
   logic                  req_ready_c;
   logic                  rsp_valid_c;
   logic                  busy_c;

   assign req_idx   = bus.req_addr[ADDR_W-1 -: SEG_IDX_W];
   assign mapped    = SEG_EN[req_idx];
   assign sel_ready = bus.seg_req_ready[idx];
   assign sel_rsp   = bus.seg_rsp_valid[idx];
   assign sel_rdata = bus.seg_rsp_rdata[int'(idx)*DATA_W +: DATA_W];
   // The counter lags by one, so this fires in the TIMEOUT-th cycle spent in ISSUE/WAIT.
   assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      capture     = 1'b0;
      cap_err     = 1'b0;
      cap_data    = '0;
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      busy_c      = 1'b1;

      case (state)
         S_IDLE: begin
            req_ready_c = 1'b1;
            busy_c      = 1'b0;
            if (bus.req_valid) begin
               accept = 1'b1;
               if (!mapped) begin
                  state_next = S_RESP;
                  capture    = 1'b1;
                  cap_err    = 1'b1;
               end else begin
                  state_next = S_ISSUE;
               end
            end
         end

         // A same-cycle segment response always beats the timeout.
         S_ISSUE: begin
            if (sel_ready && sel_rsp) begin
               state_next = S_RESP;
               capture    = 1'b1;
               cap_data   = sel_rdata;
            end else if (tmo_hit) begin
               state_next = S_RESP;
               capture    = 1'b1;
               cap_err    = 1'b1;
               cap_data   = '1;
            end else if (sel_ready) begin
               state_next = S_WAIT;
            end
         end

         S_WAIT: begin
            if (sel_rsp) begin
               state_next = S_RESP;
               capture    = 1'b1;
               cap_data   = sel_rdata;
            end else if (tmo_hit) begin
               state_next = S_RESP;
               capture    = 1'b1;
               cap_err    = 1'b1;
               cap_data   = '1;
            end
         end

         S_RESP: begin
            rsp_valid_c = 1'b1;
            state_next  = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx         <= '0;
         seg_addr_q  <= '0;
         seg_we_q    <= 1'b0;
         seg_wdata_q <= '0;
         seg_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         tmo_cnt     <= '0;
         err_cnt_q   <= '0;
      end else begin
         // Unmapped requests never touch the shared segment-side request lines.
         if (accept && mapped) begin
            idx         <= req_idx;
            seg_addr_q  <= bus.req_addr[SEG_ADDR_W-1:0];
            seg_we_q    <= bus.req_we;
            seg_wdata_q <= bus.req_wdata;
         end

         if (accept) begin
            tmo_cnt <= '0;
         end else if (state == S_ISSUE || state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end

         if (state_next != S_ISSUE) begin
            seg_valid_q <= '0;
         end else if (accept) begin
            seg_valid_q <= N_SEG'(1) << req_idx;
         end

         if (capture) begin
            rsp_rdata_q <= cap_data;
            rsp_err_q   <= cap_err;
         end

         if (state == S_RESP && rsp_err_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign bus.req_ready     = req_ready_c;
   assign bus.rsp_valid     = rsp_valid_c;
   assign bus.rsp_rdata     = rsp_rdata_q;
   assign bus.rsp_err       = rsp_err_q;
   assign bus.seg_req_valid = seg_valid_q;
   assign bus.seg_req_addr  = seg_addr_q;
   assign bus.seg_req_we    = seg_we_q;
   assign bus.seg_req_wdata = seg_wdata_q;
   assign err_count         = err_cnt_q;
   assign busy              = busy_c;

endmodule

// File: tb/tb_dbg_seg_router.sv
// Directed bench for dbg_seg_router: three differently parametrised routers share one clock
// and reset; expected responses are queued on request and popped when rsp_valid shows up.
module tb_dbg_seg_router;

   typedef struct {
      int          cyc;
      logic        err;
      logic [15:0] rdata;
   } exp_t;

   typedef struct packed {
      logic        rv;
      logic [15:0] rd;
      logic        re;
      logic [7:0]  sv;
      logic [15:0] sa;
      logic        sw;
      logic [15:0] swd;
      logic        rr;
      logic        bz;
      logic [7:0]  ec;
   } obs_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   logic [7:0] m_ec, t_ec, w_ec;
   logic       m_busy, t_busy, w_busy;

   dbg_seg_router_if #(.ADDR_W(14), .SEG_IDX_W(2), .DATA_W(8))  m_if ();
   dbg_seg_router_if #(.ADDR_W(14), .SEG_IDX_W(2), .DATA_W(8))  t_if ();
   dbg_seg_router_if #(.ADDR_W(16), .SEG_IDX_W(3), .DATA_W(16)) w_if ();

   dbg_seg_router #(.ADDR_W(14), .SEG_IDX_W(2), .DATA_W(8), .SEG_EN(4'b1111), .TIMEOUT(16)) u_main (
      .clk(clk), .rst(rst), .bus(m_if), .err_count(m_ec), .busy(m_busy));

   dbg_seg_router #(.ADDR_W(14), .SEG_IDX_W(2), .DATA_W(8), .SEG_EN(4'b1011), .TIMEOUT(4)) u_tmo (
      .clk(clk), .rst(rst), .bus(t_if), .err_count(t_ec), .busy(t_busy));

   dbg_seg_router #(.ADDR_W(16), .SEG_IDX_W(3), .DATA_W(16), .SEG_EN(8'hFF), .TIMEOUT(16)) u_wide (
      .clk(clk), .rst(rst), .bus(w_if), .err_count(w_ec), .busy(w_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic obs_t observe(input int sel);
      obs_t o;
      o = '0;
      case (sel)
         0: begin
            o.rv = m_if.rsp_valid;  o.rd = 16'(m_if.rsp_rdata);   o.re = m_if.rsp_err;
            o.sv = 8'(m_if.seg_req_valid); o.sa = 16'(m_if.seg_req_addr);
            o.sw = m_if.seg_req_we; o.swd = 16'(m_if.seg_req_wdata);
            o.rr = m_if.req_ready;  o.bz = m_busy; o.ec = m_ec;
         end
         1: begin
            o.rv = t_if.rsp_valid;  o.rd = 16'(t_if.rsp_rdata);   o.re = t_if.rsp_err;
            o.sv = 8'(t_if.seg_req_valid); o.sa = 16'(t_if.seg_req_addr);
            o.sw = t_if.seg_req_we; o.swd = 16'(t_if.seg_req_wdata);
            o.rr = t_if.req_ready;  o.bz = t_busy; o.ec = t_ec;
         end
         default: begin
            o.rv = w_if.rsp_valid;  o.rd = w_if.rsp_rdata;        o.re = w_if.rsp_err;
            o.sv = w_if.seg_req_valid; o.sa = w_if.seg_req_addr;
            o.sw = w_if.seg_req_we; o.swd = w_if.seg_req_wdata;
            o.rr = w_if.req_ready;  o.bz = w_busy; o.ec = w_ec;
         end
      endcase
      return o;
   endfunction

   task automatic drive_req(input int sel, input logic v, input logic [15:0] addr,
                            input logic we, input logic [15:0] wdata);
      case (sel)
         0: begin
            m_if.req_valid = v; m_if.req_addr = addr[13:0]; m_if.req_we = we; m_if.req_wdata = wdata[7:0];
         end
         1: begin
            t_if.req_valid = v; t_if.req_addr = addr[13:0]; t_if.req_we = we; t_if.req_wdata = wdata[7:0];
         end
         default: begin
            w_if.req_valid = v; w_if.req_addr = addr; w_if.req_we = we; w_if.req_wdata = wdata;
         end
      endcase
   endtask

   // Stray responses always come from the neighbouring segment (seg ^ 1).
   task automatic drive_seg(input int sel, input int seg, input logic rdy, input logic rsp,
                            input logic stray, input logic [15:0] rdata);
      case (sel)
         0: begin
            m_if.seg_req_ready = '0; m_if.seg_rsp_valid = '0;
            m_if.seg_req_ready[seg] = rdy;
            m_if.seg_rsp_valid[seg] = rsp;
            if (stray) m_if.seg_rsp_valid[seg ^ 1] = 1'b1;
            m_if.seg_rsp_rdata[seg*8 +: 8] = rdata[7:0];
         end
         1: begin
            t_if.seg_req_ready = '0; t_if.seg_rsp_valid = '0;
            t_if.seg_req_ready[seg] = rdy;
            t_if.seg_rsp_valid[seg] = rsp;
            if (stray) t_if.seg_rsp_valid[seg ^ 1] = 1'b1;
            t_if.seg_rsp_rdata[seg*8 +: 8] = rdata[7:0];
         end
         default: begin
            w_if.seg_req_ready = '0; w_if.seg_rsp_valid = '0;
            w_if.seg_req_ready[seg] = rdy;
            w_if.seg_rsp_valid[seg] = rsp;
            if (stray) w_if.seg_rsp_valid[seg ^ 1] = 1'b1;
            w_if.seg_rsp_rdata[seg*16 +: 16] = rdata;
         end
      endcase
   endtask

   task automatic check_reset(input int sel, input string tag);
      obs_t o;
      o = observe(sel);
      check_output({tag, "_zero"}, 32'({o.rv, o.rd, o.re, o.sv}), 32'd0);
      check_output({tag, "_seg"},  32'({o.sa, o.sw, o.swd}),     32'd0);
      check_output({tag, "_ctl"},  32'({o.rr, o.bz, o.ec}),      32'h200);
   endtask

   // One complete transaction: request at cycle 0, segment ready/response at the given cycles.
   task automatic apply_stimulus(input int sel, input logic [15:0] addr, input logic we,
                                 input logic [15:0] wdata, input int seg, input int rdy_cyc,
                                 input int rsp_cyc, input int stray_cyc, input logic [15:0] seg_rdata,
                                 input logic [15:0] exp_local, input int exp_issue, input int exp_cyc,
                                 input logic exp_err, input logic [15:0] exp_rdata);
      obs_t       o;
      exp_t       e;
      int         issue_cnt;
      int         viol;
      int         got_cyc;
      logic [7:0] oh;
      oh        = 8'(1) << seg;
      issue_cnt = 0;
      viol      = 0;
      got_cyc   = -1;
      sb.push_back('{exp_cyc, exp_err, exp_rdata});
      o = observe(sel);
      check_output("req_ready_idle", 32'(o.rr), 32'd1);
      drive_req(sel, 1'b1, addr, we, wdata);
      tick();
      drive_req(sel, 1'b0, 16'h0, 1'b0, 16'h0);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         drive_seg(sel, seg, cyc == rdy_cyc, cyc == rsp_cyc, cyc == stray_cyc, seg_rdata);
         o = observe(sel);
         if (o.rv) begin
            got_cyc = cyc;
            if (o.sv !== 8'h0) viol++;
            break;
         end
         if (o.sv === oh) begin
            issue_cnt++;
            if (o.sa !== exp_local || o.sw !== we || o.swd !== wdata) viol++;
         end else if (o.sv !== 8'h0) begin
            viol++;
         end
         tick();
      end
      drive_seg(sel, seg, 1'b0, 1'b0, 1'b0, seg_rdata);
      e = sb.pop_front();
      check_output("rsp_latency", 32'(got_cyc), 32'(e.cyc));
      if (got_cyc >= 0) begin
         check_output("rsp_err",   32'(o.re), 32'(e.err));
         check_output("rsp_rdata", 32'(o.rd), 32'(e.rdata));
      end
      check_output("seg_issue_cycles", 32'(issue_cnt), 32'(exp_issue));
      check_output("seg_req_lines",    32'(viol),      32'd0);
      tick();
      o = observe(sel);
      check_output("rsp_single_pulse", 32'({o.rv, o.rr}), 32'b01);
   endtask

   initial begin
      obs_t o;
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      drive_req(0, 1'b0, 16'h0, 1'b0, 16'h0);
      drive_req(1, 1'b0, 16'h0, 1'b0, 16'h0);
      drive_req(2, 1'b0, 16'h0, 1'b0, 16'h0);
      m_if.seg_req_ready = '0; m_if.seg_rsp_valid = '0; m_if.seg_rsp_rdata = 32'hD4C3B2A1;
      t_if.seg_req_ready = '0; t_if.seg_rsp_valid = '0; t_if.seg_rsp_rdata = 32'h44332211;
      w_if.seg_req_ready = '0; w_if.seg_rsp_valid = '0;
      w_if.seg_rsp_rdata = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
      tick();
      tick();
      rst = 1'b0;
      $display("[TB] reset values");
      check_reset(0, "rst_main");
      check_reset(1, "rst_tmo");
      check_reset(2, "rst_wide");

      $display("[TB] mapped read, immediate segment");
      apply_stimulus(0, 16'h1005, 1'b0, 16'h0, 1, 1, 1, 0, 16'h00A5,
                     16'h0005, 1, 2, 1'b0, 16'h00A5);

      $display("[TB] write with delayed ack");
      apply_stimulus(0, 16'h2010, 1'b1, 16'h003C, 2, 3, 6, 0, 16'h0099,
                     16'h0010, 3, 7, 1'b0, 16'h0099);

      $display("[TB] stray response from another segment");
      apply_stimulus(0, 16'h1F00, 1'b0, 16'h0, 1, 2, 5, 3, 16'h00C3,
                     16'h0F00, 2, 6, 1'b0, 16'h00C3);
      o = observe(0);
      check_output("main_err_count", 32'(o.ec), 32'd0);

      $display("[TB] reset during WAIT");
      drive_req(0, 1'b1, 16'h2040, 1'b0, 16'h0);
      tick();
      drive_req(0, 1'b0, 16'h0, 1'b0, 16'h0);
      drive_seg(0, 2, 1'b1, 1'b0, 1'b0, 16'h0055);
      tick();
      drive_seg(0, 2, 1'b0, 1'b0, 1'b0, 16'h0055);
      o = observe(0);
      check_output("busy_in_wait", 32'({o.bz, o.rr}), 32'b10);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset(0, "mid_rst");
      drive_seg(0, 2, 1'b0, 1'b1, 1'b0, 16'h0066);
      tick();
      drive_seg(0, 2, 1'b0, 1'b0, 1'b0, 16'h0066);
      o = observe(0);
      check_output("late_rsp_ignored", 32'({o.rv, o.bz, o.rr}), 32'b001);
      apply_stimulus(0, 16'h3ABC, 1'b0, 16'h0, 3, 2, 2, 0, 16'h0077,
                     16'h0ABC, 2, 3, 1'b0, 16'h0077);

      $display("[TB] unmapped segment");
      apply_stimulus(1, 16'h2123, 1'b0, 16'h0, 2, 0, 0, 0, 16'h0000,
                     16'h0000, 0, 1, 1'b1, 16'h0000);
      o = observe(1);
      check_output("unmapped_err_count", 32'(o.ec), 32'd1);

      $display("[TB] timeout, segment never ready");
      apply_stimulus(1, 16'h3001, 1'b0, 16'h0, 3, 0, 0, 0, 16'h0000,
                     16'h0001, 4, 5, 1'b1, 16'h00FF);
      o = observe(1);
      check_output("timeout_err_count", 32'(o.ec), 32'd2);

      $display("[TB] response on the timeout cycle");
      apply_stimulus(1, 16'h3002, 1'b0, 16'h0, 3, 2, 4, 0, 16'h005A,
                     16'h0002, 2, 5, 1'b0, 16'h005A);
      o = observe(1);
      check_output("late_ok_err_count", 32'(o.ec), 32'd2);

      $display("[TB] wide configuration, segment 7");
      apply_stimulus(2, 16'hE123, 1'b0, 16'h0, 7, 1, 2, 0, 16'hBEEF,
                     16'h0123, 1, 3, 1'b0, 16'hBEEF);

      $display("[TB] error counter saturation");
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(1, 16'h2000 + 16'(i), 1'b0, 16'h0, 2, 0, 0, 0, 16'h0000,
                        16'h0000, 0, 1, 1'b1, 16'h0000);
      end
      o = observe(1);
      check_output("err_count_saturated", 32'(o.ec), 32'd255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
